ibex_fetch_queue: RTL

IBEX_FETCH_QUEUE -- requirements
Module: ibex_fetch_queue

---
 rtl/ibex_pkg.sv | 15 +
 rtl/ibex_fetch_queue_ctrl.sv | 53 +++++
 rtl/ibex_fetch_queue.sv | 106 ++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared fetch-entry type and fetch queue limits
package ibex_pkg;

  localparam int unsigned FetchQueueDepthMin = 2;
  localparam int unsigned FetchQueueDepthMax = 16;
  localparam int unsigned FetchDataWidthMax  = 64;

  // One buffered fetch word; rdata is sized for the widest supported DataWidth.
  typedef struct packed {
    logic [FetchDataWidthMax-1:0] rdata;
    logic [31:0]                  addr;
    logic                         err;
  } fetch_entry_t;

endpackage

// File: rtl/ibex_fetch_queue_ctrl.sv
// rtl/ibex_fetch_queue_ctrl.sv - read/write pointers and occupancy of the fetch queue
module ibex_fetch_queue_ctrl #(
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  output logic [$clog2(Depth)-1:0]   wr_ptr,
  output logic [$clog2(Depth)-1:0]   rd_ptr,
  output logic [$clog2(Depth+1)-1:0] occupancy
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [PtrW-1:0] wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_d;
  logic [CntW-1:0] occ_d;

  // Pointers wrap explicitly at Depth-1 so non-power-of-two depths work; flush wins.
  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    occ_d    = occupancy;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      occ_d = occupancy + 1'b1;
      else if (pop && !push) occ_d = occupancy - 1'b1;
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      wr_ptr    <= wr_ptr_d;
      rd_ptr    <= rd_ptr_d;
      occupancy <= occ_d;
    end
  end

endmodule

// File: rtl/ibex_fetch_queue.sv
// rtl/ibex_fetch_queue.sv - instruction fetch FIFO; IBEX_FETCH_QUEUE_BYPASS_EN adds an empty-queue bypass
module ibex_fetch_queue
  import ibex_pkg::*;
#(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 32,
  parameter bit          ResetAll  = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DataWidth-1:0]       in_rdata_i,
  input  logic [31:0]                in_addr_i,
  input  logic                       in_err_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DataWidth-1:0]       out_rdata_o,
  output logic [31:0]                out_addr_o,
  output logic                       out_err_o,
  output logic [$clog2(Depth+1)-1:0] occupancy_o,
  output logic                       busy_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  if (Depth < FetchQueueDepthMin || Depth > FetchQueueDepthMax ||
      DataWidth > FetchDataWidthMax) begin : g_param_err
    $error("ibex_fetch_queue: unsupported Depth or DataWidth");
  end

  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] occupancy;
  logic            empty;
  logic            push;
  logic            pop;
  logic            store;
  fetch_entry_t    in_entry;
  fetch_entry_t    mem [Depth];

  assign empty       = (occupancy == '0);
  assign in_ready_o  = (occupancy != CntW'(Depth));
  assign push        = in_valid_i & in_ready_o;
  assign occupancy_o = occupancy;
  assign busy_o      = ~empty;

`ifdef IBEX_FETCH_QUEUE_BYPASS_EN
  logic bypass;
  // An empty queue shows the incoming word directly; if ID takes it, it never enters storage.
  assign bypass      = empty & in_valid_i;
  assign out_valid_o = ~empty | in_valid_i;
  assign out_rdata_o = bypass ? in_rdata_i : mem[rd_ptr].rdata[DataWidth-1:0];
  assign out_addr_o  = bypass ? in_addr_i  : mem[rd_ptr].addr;
  assign out_err_o   = bypass ? in_err_i   : mem[rd_ptr].err;
  assign pop         = ~empty & out_ready_i;
  assign store       = push & ~(bypass & out_ready_i);
`else
  assign out_valid_o = ~empty;
  assign out_rdata_o = mem[rd_ptr].rdata[DataWidth-1:0];
  assign out_addr_o  = mem[rd_ptr].addr;
  assign out_err_o   = mem[rd_ptr].err;
  assign pop         = out_valid_o & out_ready_i;
  assign store       = push;
`endif

  // Pack the incoming word into a storage entry, unused rdata bits held at zero.
  always_comb begin
    in_entry                      = '0;
    in_entry.rdata[DataWidth-1:0] = in_rdata_i;
    in_entry.addr                 = in_addr_i;
    in_entry.err                  = in_err_i;
  end

  ibex_fetch_queue_ctrl #(
    .Depth(Depth)
  ) u_ctrl (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush    (flush_i),
    .push     (store),
    .pop      (pop),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .occupancy(occupancy)
  );

  if (ResetAll) begin : g_mem_rst
    // Entry storage with reset, so the head fields read zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < Depth; i++) mem[i] <= '0;
      end else if (store && !flush_i) begin
        mem[wr_ptr] <= in_entry;
      end
    end
  end else begin : g_mem_nr
    // Entry storage without reset; contents are only observed while valid.
    always_ff @(posedge clk_i) begin
      if (store && !flush_i) mem[wr_ptr] <= in_entry;
    end
  end

endmodule
